// File: rtl/seg_ring_shifter_if.sv
// Board-facing signal bundle of the segment ring shifter: key/switch inputs
// toward the shifter and the HEX/LEDR/LEDG/step outputs back to the pins.
interface seg_ring_shifter_if #(
  parameter int NUM_DIGITS = 4,
  parameter int LED_W      = 10,
  parameter int SPEED_MAX  = 7
);
  localparam int LVL_W = (SPEED_MAX > 0) ? $clog2(SPEED_MAX + 1) : 1;

  logic                    speed_up;
  logic                    speed_down;
  logic                    dir_right;
  logic                    dir_left;
  logic                    fill_one;
  logic                    fill_zero;
  logic [7*NUM_DIGITS-1:0] hex_n;
  logic [LED_W-1:0]        ledr;
  logic [SPEED_MAX:0]      ledg;
  logic [LVL_W-1:0]        speed_level;
  logic                    step;

  modport master (
    output speed_up, speed_down, dir_right, dir_left, fill_one, fill_zero,
    input  hex_n, ledr, ledg, speed_level, step
  );

  modport slave (
    input  speed_up, speed_down, dir_right, dir_left, fill_one, fill_zero,
    output hex_n, ledr, ledg, speed_level, step
  );
endinterface

// File: rtl/seg_ring_shifter.sv
// Segment ring shifter: walks a lit-segment pattern along a snake path through
// the 7-seg digits and rotates/fills the LED bank in lockstep. Two debounced
// keys move a saturating speed level that divides the shift period.
module seg_ring_shifter #(
  parameter int NUM_DIGITS   = 4,
  parameter int LED_W        = 10,
  parameter int BASE_PERIOD  = 50_000_000,
  parameter int SPEED_MAX    = 7,
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  seg_ring_shifter_if.slave bus
);
  localparam int P     = 5 * NUM_DIGITS;
  localparam int HEX_W = 7 * NUM_DIGITS;
  localparam int LVL_W = (SPEED_MAX > 0) ? $clog2(SPEED_MAX + 1) : 1;
  localparam int CNT_W = $clog2(BASE_PERIOD + 1);
  localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BASE_PERIOD - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [LVL_W-1:0] LVL_TOP  = LVL_W'(SPEED_MAX);
  localparam logic [P-1:0]     PATH_RST = {P{1'b1}} >> (P - P/2);
  localparam logic [LED_W-1:0] LED_RST  = {LED_W{1'b1}} >> (LED_W - LED_W/2);

  // bit positions inside the synchroniser vector
  localparam int SU = 0;
  localparam int SD = 1;
  localparam int DR = 2;
  localparam int DL = 3;
  localparam int F1 = 4;
  localparam int F0 = 5;

  logic [5:0]            raw_in;
  logic [5:0]            sync_a;
  logic [5:0]            sync_b;
  logic [1:0][DB_W-1:0]  db_cnt;
  logic [1:0]            btn_acc;
  logic [1:0]            btn_rise;
  logic [LVL_W-1:0]      level;
  logic [LVL_W-1:0]      level_nxt;
  logic [SPEED_MAX:0]    ledg_q;
  logic [SPEED_MAX:0]    ledg_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      period_m1;
  logic [P-1:0]          path;
  logic [P-1:0]          path_nxt;
  logic [LED_W-1:0]      led;
  logic [LED_W-1:0]      led_nxt;
  logic [HEX_W-1:0]      hex_q;
  logic                  step_q;
  logic                  step_nxt;
  logic                  shift_tick;
  logic                  go_right;
  logic                  go_left;
  logic                  path_in;
  logic                  led_in;

  // Segment index (bit0 = a) visited at step j of digit k counted from the left.
  // Even digits run a,b,g,e,d; odd digits run d,c,g,f,a, forming the snake.
  function automatic int seg_of(input int k, input int j);
    int s;
    s = 0;
    if (k % 2 == 0) begin
      case (j)
        0:       s = 0;
        1:       s = 1;
        2:       s = 6;
        3:       s = 4;
        default: s = 3;
      endcase
    end else begin
      case (j)
        0:       s = 3;
        1:       s = 2;
        2:       s = 6;
        3:       s = 5;
        default: s = 0;
      endcase
    end
    return s;
  endfunction

  // Off-path segments stay dark; path bits are active-high, pins active-low.
  function automatic logic [HEX_W-1:0] path_to_hex(input logic [P-1:0] pth);
    logic [HEX_W-1:0] h;
    h = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      for (int j = 0; j < 5; j++) begin
        h[7*(NUM_DIGITS-1-k) + seg_of(k, j)] = ~pth[5*k + j];
      end
    end
    return h;
  endfunction

  assign raw_in = {bus.fill_zero, bus.fill_one, bus.dir_left, bus.dir_right,
                   bus.speed_down, bus.speed_up};

  // Two-flop synchroniser for every board input.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw_in;
      sync_b <= sync_a;
    end
  end

  // Accepted key state flips once the synced level has disagreed for DEBOUNCE_CYC cycles.
  always_comb begin
    btn_rise = '0;
    for (int b = 0; b < 2; b++) begin
      btn_rise[b] = (sync_b[b] != btn_acc[b]) && (db_cnt[b] == DB_LAST) && sync_b[b];
    end
  end

  // Debounce counters track consecutive disagreement cycles per key.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      db_cnt  <= '0;
      btn_acc <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (sync_b[b] != btn_acc[b]) begin
          if (db_cnt[b] == DB_LAST) begin
            btn_acc[b] <= sync_b[b];
            db_cnt[b]  <= '0;
          end else begin
            db_cnt[b] <= db_cnt[b] + 1'b1;
          end
        end else begin
          db_cnt[b] <= '0;
        end
      end
    end
  end

  // Saturating level update; simultaneous up/down edges cancel.
  always_comb begin
    level_nxt = level;
    ledg_nxt  = '0;
    if (btn_rise[SU] && !btn_rise[SD] && level != LVL_TOP) begin
      level_nxt = level + 1'b1;
    end else if (btn_rise[SD] && !btn_rise[SU] && level != '0) begin
      level_nxt = level - 1'b1;
    end
    for (int i = 0; i <= SPEED_MAX; i++) begin
      ledg_nxt[i] = (i <= int'(level_nxt));
    end
  end

  // Speed level and its thermometer bar.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      level  <= '0;
      ledg_q <= '0 | 1'b1;
    end else begin
      level  <= level_nxt;
      ledg_q <= ledg_nxt;
    end
  end

  // Reload value follows the level sampled at the reload itself, so a level
  // change only shortens or stretches the period after the current one ends.
  assign period_m1 = CNT_W'((BASE_PERIOD >> level) - 1);

  // Period down-counter; terminal count marks the shift cycle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt <= CNT_INIT;
    end else if (cnt == '0) begin
      cnt <= period_m1;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  // Next pattern: rotate by default, forced fill when exactly one fill key is on.
  always_comb begin
    shift_tick = (cnt == '0);
    go_right   = sync_b[DR];
    go_left    = sync_b[DL] & ~sync_b[DR];
    path_in    = go_right ? path[P-1] : path[0];
    led_in     = go_right ? led[0] : led[LED_W-1];
    if (sync_b[F1] && !sync_b[F0]) begin
      path_in = 1'b1;
      led_in  = 1'b1;
    end else if (sync_b[F0] && !sync_b[F1]) begin
      path_in = 1'b0;
      led_in  = 1'b0;
    end
    path_nxt = path;
    led_nxt  = led;
    step_nxt = 1'b0;
    if (shift_tick && go_right) begin
      path_nxt = {path[P-2:0], path_in};
      led_nxt  = {led_in, led[LED_W-1:1]};
      step_nxt = 1'b1;
    end else if (shift_tick && go_left) begin
      path_nxt = {path_in, path[P-1:1]};
      led_nxt  = {led[LED_W-2:0], led_in};
      step_nxt = 1'b1;
    end
  end

  // Pattern, LED bank, segment decode and strobe update in the same cycle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      path   <= PATH_RST;
      led    <= LED_RST;
      hex_q  <= path_to_hex(PATH_RST);
      step_q <= 1'b0;
    end else begin
      path   <= path_nxt;
      led    <= led_nxt;
      hex_q  <= path_to_hex(path_nxt);
      step_q <= step_nxt;
    end
  end

  assign bus.hex_n       = hex_q;
  assign bus.ledr        = led;
  assign bus.ledg        = ledg_q;
  assign bus.speed_level = level;
  assign bus.step        = step_q;
endmodule

// File: tb/tb_seg_ring_shifter.sv
// Bench for seg_ring_shifter: queue-based reference model of the path and LED
// bank, scoreboard popped by a monitor on every step strobe.
`timescale 1ns/1ps
module tb_seg_ring_shifter;
  localparam int ND = 4;
  localparam int LW = 10;
  localparam int BP = 16;
  localparam int SM = 3;
  localparam int DB = 4;
  localparam int P  = 5 * ND;

  localparam logic [27:0] HEX_RST  = {7'b0100100, 7'b0010010, 7'h7F, 7'h7F};
  localparam logic [27:0] HEX_FULL = {7'b0100100, 7'b0010010, 7'b0100100, 7'b0010010};

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seg_ring_shifter_if #(.NUM_DIGITS(ND), .LED_W(LW), .SPEED_MAX(SM)) bus ();

  seg_ring_shifter #(
    .NUM_DIGITS(ND), .LED_W(LW), .BASE_PERIOD(BP), .SPEED_MAX(SM), .DEBOUNCE_CYC(DB)
  ) dut (
    .CLOCK_50(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [27:0] hex;
    logic [9:0]  led;
  } exp_t;

  exp_t sbq[$];
  bit   mp[$];   // mp[i] = path position i lit
  bit   ml[$];   // ml[i] = ledr[i]
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int seg_idx(input int k, input int j);
    string s;
    s = (k % 2 == 0) ? "abged" : "dcgfa";
    return int'(s[j]) - 97;
  endfunction

  function automatic logic [27:0] model_hex();
    logic [27:0] h;
    h = '1;
    for (int p = 0; p < P; p++)
      if (mp[p]) h[7*(ND-1-p/5) + seg_idx(p/5, p%5)] = 1'b0;
    return h;
  endfunction

  function automatic logic [9:0] model_led();
    logic [9:0] l;
    for (int i = 0; i < LW; i++) l[i] = ml[i];
    return l;
  endfunction

  function automatic void model_reset();
    mp.delete();
    ml.delete();
    for (int p = 0; p < P; p++) mp.push_back(p < P/2);
    for (int i = 0; i < LW; i++) ml.push_back(i < LW/2);
  endfunction

  // Advances the model one step and queues the expected outputs.
  function automatic void model_step(input bit dr, input bit dl, input bit f1, input bit f0);
    bit lp, ll;
    exp_t e;
    if (!dr && !dl) return;
    if (dr) begin
      lp = mp.pop_back();
      ll = ml.pop_front();
      mp.push_front((f1 && !f0) ? 1'b1 : (f0 && !f1) ? 1'b0 : lp);
      ml.push_back ((f1 && !f0) ? 1'b1 : (f0 && !f1) ? 1'b0 : ll);
    end else begin
      lp = mp.pop_front();
      ll = ml.pop_back();
      mp.push_back ((f1 && !f0) ? 1'b1 : (f0 && !f1) ? 1'b0 : lp);
      ml.push_front((f1 && !f0) ? 1'b1 : (f0 && !f1) ? 1'b0 : ll);
    end
    e.hex = model_hex();
    e.led = model_led();
    sbq.push_back(e);
  endfunction

  // Monitor: every step strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && bus.step === 1'b1) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_step: got step=1 expected no step at %0t", $time);
      end else begin
        e = sbq.pop_front();
        chk("step_hex", {4'h0, bus.hex_n}, {4'h0, e.hex});
        chk("step_ledr", {22'h0, bus.ledr}, {22'h0, e.led});
      end
    end
  end

  task automatic drive(input bit dr, input bit dl, input bit f1, input bit f0);
    bus.dir_right = dr;
    bus.dir_left  = dl;
    bus.fill_one  = f1;
    bus.fill_zero = f0;
  endtask

  task automatic wait_step(input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.step !== 1'b1 && n < exp_n + 20);
    chk("step_period", n, exp_n);
  endtask

  // One shift period starting at the negedge where the previous step showed.
  task automatic slot(input bit dr, input bit dl, input bit f1, input bit f0, input int per);
    drive(dr, dl, f1, f0);
    if (dr || dl) begin
      model_step(dr, dl, f1, f0);
      wait_step(per);
    end else begin
      repeat (per) @(negedge clk);
    end
  endtask

  // Start shifting from an unknown counter phase; realigns to the step strobe.
  task automatic resync(input bit dr, input bit dl, input bit f1, input bit f0);
    int n;
    drive(dr, dl, f1, f0);
    model_step(dr, dl, f1, f0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.step !== 1'b1 && n < BP + 20);
    chk("resync_step", {31'h0, bus.step}, 32'h1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_hex", {4'h0, bus.hex_n}, {4'h0, HEX_RST});
    chk("rst_ledr", {22'h0, bus.ledr}, 32'h01F);
    chk("rst_ledg", {28'h0, bus.ledg}, 32'h1);
    chk("rst_level", {30'h0, bus.speed_level}, 32'h0);
    chk("rst_step", {31'h0, bus.step}, 32'h0);
    sbq.delete();
    model_reset();
    reset = 1'b0;
  endtask

  task automatic press(input bit up, input bit dn, input int hold, input int exp_lvl, input string tag);
    bus.speed_up   = up;
    bus.speed_down = dn;
    repeat (hold) @(negedge clk);
    chk({tag, "_held"}, {30'h0, bus.speed_level}, exp_lvl);
    bus.speed_up   = 1'b0;
    bus.speed_down = 1'b0;
    repeat (12) @(negedge clk);
    chk({tag, "_level"}, {30'h0, bus.speed_level}, exp_lvl);
    chk({tag, "_ledg"}, {28'h0, bus.ledg}, (32'h1 << (exp_lvl + 1)) - 1);
  endtask

  task automatic freeze(input int cycles);
    logic [27:0] h;
    logic [9:0]  l;
    int bad;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    h = bus.hex_n;
    l = bus.ledr;
    bad = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.step !== 1'b0 || bus.hex_n !== h || bus.ledr !== l) bad++;
    end
    chk("frozen_changes", bad, 0);
    chk("frozen_hex_model", {4'h0, bus.hex_n}, {4'h0, model_hex()});
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit dr, dl, f1, f0;
    reset = 1'b1;
    bus.speed_up   = 1'b0;
    bus.speed_down = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    do_reset();

    // Right rotate from reset: 20 steps return the hex pattern, LEDs repeat every 10.
    for (int i = 0; i < 20; i++) begin
      slot(1'b1, 1'b0, 1'b0, 1'b0, BP);
      if (i == 0) begin
        chk("first_hex_d3", {25'h0, bus.hex_n[27:21]}, 32'b0100101);
        chk("first_hex_d1", {25'h0, bus.hex_n[13:7]}, 32'b1111110);
        chk("first_ledr", {22'h0, bus.ledr}, 32'h20F);
      end
      if (i == 9) chk("ledr_10_steps", {22'h0, bus.ledr}, 32'h01F);
    end
    chk("hex_20_steps", {4'h0, bus.hex_n}, {4'h0, HEX_RST});

    // Both directions behave as right; none freezes the pattern.
    for (int i = 0; i < 4; i++) slot(1'b1, 1'b1, 1'b0, 1'b0, BP);
    freeze(7 * BP);

    // Left fill with ones, then zeros.
    for (int i = 0; i < 20; i++) slot(1'b0, 1'b1, 1'b1, 1'b0, BP);
    chk("fill_one_hex", {4'h0, bus.hex_n}, {4'h0, HEX_FULL});
    chk("fill_one_ledr", {22'h0, bus.ledr}, 32'h3FF);
    for (int i = 0; i < 20; i++) slot(1'b0, 1'b1, 1'b0, 1'b1, BP);
    chk("fill_zero_hex", {4'h0, bus.hex_n}, 32'h0FFFFFFF);
    chk("fill_zero_ledr", {22'h0, bus.ledr}, 32'h0);
    slot(1'b0, 1'b0, 1'b0, 1'b0, BP);

    // Speed keys.
    press(1'b0, 1'b1, 10, 0, "down_at_0");
    press(1'b1, 1'b0, 2, 0, "glitch_up");
    press(1'b1, 1'b0, 10, 1, "up_1");

    do_reset();
    press(1'b1, 1'b0, 10, 1, "up_again");
    resync(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      dr = 1'($urandom_range(0, 1));
      slot(dr, ~dr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), BP >> 1);
    end
    slot(1'b0, 1'b0, 1'b0, 1'b0, BP >> 1);
    press(1'b1, 1'b0, 10, 2, "up_2");
    press(1'b1, 1'b0, 10, 3, "up_3");
    press(1'b1, 1'b0, 10, 3, "up_sat_a");
    press(1'b1, 1'b0, 10, 3, "up_sat_b");

    // Fastest rate: inputs held constant, then one in-flight step while stopping.
    resync(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) slot(1'b1, 1'b0, 1'b0, 1'b0, BP >> SM);
    model_step(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    wait_step(BP >> SM);
    repeat (8) @(negedge clk);
    press(1'b0, 1'b1, 10, 2, "down_2");

    // Reset mid-count at level 2.
    resync(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) slot(1'b1, 1'b0, 1'b0, 1'b0, BP >> 2);
    @(negedge clk);
    do_reset();
    slot(1'b1, 1'b0, 1'b0, 1'b0, BP);

    // Random directions and fills at level 0.
    for (int i = 0; i < 40; i++) begin
      dr = 1'($urandom_range(0, 1));
      dl = 1'($urandom_range(0, 1));
      f1 = 1'($urandom_range(0, 1));
      f0 = 1'($urandom_range(0, 1));
      slot(dr, dl, f1, f0, BP);
    end

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
